// File: rtl/mfe_pkg.sv
// Shared median-filter-engine constants, FSM state type and result-memory address map.
// No logic of its own; imported by the engine and the result streamer.
// Address is {x, y} with x the column, so raster order walks the high field fastest.
package mfe_pkg;
    localparam int IMG_W   = 128;
    localparam int ADDR_W  = 14;
    localparam int PIX_W   = 8;
    localparam int COORD_W = $clog2(IMG_W);
    localparam int NUM_PIX = IMG_W * IMG_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } stream_state_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return {x, y};
    endfunction
endpackage

// File: rtl/mfe_stream_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any fill level.
// Latency: a push is visible at pop_data the next cycle (same cycle when empty and popped).
// Backpressure: none internally; the writer must respect count via credit.
module mfe_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    // Push+pop on empty passes the word straight through and leaves the FIFO empty.
    assign wr_en    = push && !(empty && pop) && ((count < CNT_W'(DEPTH)) || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = (empty && push) ? push_data : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end
endmodule

// File: rtl/mfe_result_streamer.sv
// Streams the 128x128 result image out of the result memory in raster order.
// Latency: start to first out_valid is 3 cycles; one pixel per cycle when unstalled.
// Backpressure: out_ready low stops read issue once FIFO plus in-flight read reach FIFO_DEPTH.
module mfe_result_streamer
    import mfe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    stream_state_t        state;
    stream_state_t        state_nxt;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 inflight;
    logic [ADDR_W-1:0]    pix_cnt;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occ;
    logic                 pop;
    logic                 credit_ok;
    logic                 last_issue;
    logic                 start_frame;

    assign pop         = out_valid && out_ready;
    assign start_frame = (state == S_IDLE) && start;
    // Occupancy after this cycle's pop; a pop always has an entry behind it, so no underflow.
    assign occ         = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign credit_ok   = occ < (CNT_W + 1)'(FIFO_DEPTH);
    assign last_issue  = (x == COORD_W'(IMG_W - 1)) && (y == COORD_W'(IMG_W - 1));

    assign rd_addr   = pix_addr(x, y);
    assign out_valid = (fifo_count != '0);
    assign out_last  = out_valid && (pix_cnt == ADDR_W'(NUM_PIX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (rd_en && last_issue) state_nxt = S_DRAIN;
            // Exit as the last pixel handshakes so done lands the very next cycle.
            S_DRAIN: if (occ == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_RUN: begin
                rd_en = credit_ok;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            inflight <= 1'b0;
            pix_cnt  <= '0;
        end else begin
            // Memory answers one cycle after the strobe, so inflight simply follows rd_en.
            inflight <= rd_en;
            if (start_frame) begin
                x <= '0;
                y <= '0;
            end else if (rd_en) begin
                if (x == COORD_W'(IMG_W - 1)) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (start_frame) pix_cnt <= '0;
            else if (pop)    pix_cnt <= pix_cnt + 1'b1;
        end
    end

    mfe_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (rd_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_mfe_result_streamer.sv
// Scoreboard bench for mfe_result_streamer: frames are queued as expected pixels at start,
// a negedge monitor pops and compares on every handshake.
module tb_mfe_result_streamer;
    import mfe_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic [PIX_W-1:0]  rd_data = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              out_valid;
    logic [PIX_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    mfe_result_streamer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] mem_val(input logic [13:0] a);
        return a[7:0] ^ a[13:6];
    endfunction

    // Result memory: one-cycle registered read
    always @(posedge clk) if (rd_en) rd_data <= mem_val(rd_addr);

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_frame();
        logic [6:0]  px;
        logic [6:0]  py;
        logic [13:0] a;
        for (int k = 0; k < NUM_PIX; k++) begin
            px = 7'(k % IMG_W);
            py = 7'(k / IMG_W);
            a  = {px, py};
            exp_q.push_back('{data: mem_val(a), last: (k == NUM_PIX - 1)});
        end
    endtask

    // Monitor state (written only here)
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat = '0;
    logic       stall_last = 1'b0;
    logic       busy_prev = 1'b0;
    logic       armed = 1'b0;
    int         pix_seen = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         first_cyc = -1;
    int         rd_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
            busy_prev  = 1'b0;
            armed      = 1'b0;
        end else begin
            if (rd_en) rd_cnt++;
            if (busy && !busy_prev) armed = 1'b1;
            if (armed && out_valid) begin
                first_cyc = cyc;
                armed     = 1'b0;
            end
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_dat);
                check("stall_last", out_last, stall_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got data %0d, expected no pixel (cycle %0d)",
                             out_data, cyc);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pix_data", out_data, exp_e.data);
                    check("pix_last", out_last, exp_e.last);
                    pix_seen++;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_dat  = out_data;
            stall_last = out_last;
            busy_prev  = busy;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_frame(output int n0);
        @(posedge clk);
        #1;
        start = 1'b1;
        n0    = cyc;
        push_frame();
    endtask

    // Runs until done; optional ignored start pulses, a 20-cycle stall, then random ready.
    task automatic wait_done(input int n0, input bit pulses, input int stall_at, output bit ok);
        bit stalled   = 1'b0;
        int stall_left = 0;
        int rd_base   = 0;
        int pbase     = pix_seen;
        ok = 1'b0;
        for (int i = 0; i < 60000 && !ok; i++) begin
            if (stall_at > 0 && !stalled && (pix_seen - pbase) >= stall_at) begin
                stalled    = 1'b1;
                stall_left = 20;
                rd_base    = rd_cnt;
            end
            @(posedge clk);
            #1;
            start = pulses && (cyc == n0 + 100 || cyc == n0 + 5000);
            if (stall_left > 0)  out_ready = 1'b0;
            else if (stalled)    out_ready = ($urandom_range(3) != 0);
            else                 out_ready = 1'b1;
            @(negedge clk);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) check("stall_issue_bound", (rd_cnt - rd_base) <= FIFO_DEPTH, 1);
            end
            if (done) ok = 1'b1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int n0;
        int base;
        int dbase;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b1;
        base = rd_cnt;
        repeat (10) @(negedge clk);
        #1 check("idle_no_rd_en", rd_cnt - base, 0);

        // Frame 1: full speed, start pulses while busy must be ignored
        dbase = done_cnt;
        start_frame(n0);
        wait_done(n0, 1'b1, 0, ok);
        check("f1_done_seen", ok, 1);
        check("f1_first_valid_cyc", first_cyc, n0 + 3);
        check("f1_done_cyc", done_cyc, n0 + 16387);
        check("f1_done_count", done_cnt - dbase, 1);
        check("f1_all_pixels", exp_q.size(), 0);

        // Frame 2: back-to-back start, stall then random backpressure
        dbase = done_cnt;
        start_frame(n0);
        wait_done(n0, 1'b0, 1000, ok);
        check("f2_done_seen", ok, 1);
        check("f2_done_count", done_cnt - dbase, 1);
        check("f2_all_pixels", exp_q.size(), 0);

        base  = rd_cnt;
        dbase = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("post_idle_rd_en", rd_cnt - base, 0);
        check("post_idle_done", done_cnt - dbase, 0);
        check("post_idle_valid", out_valid, 0);

        // Frame 3: reset at pixel 5000
        start_frame(n0);
        base = pix_seen;
        for (int i = 0; i < 20000 && (pix_seen - base) < 5000; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            #1;
        end
        check("f3_reached_5000", pix_seen - base, 5000);
        reset = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Frame 4: complete frame after reset
        dbase = done_cnt;
        start_frame(n0);
        wait_done(n0, 1'b0, 0, ok);
        check("f4_done_seen", ok, 1);
        check("f4_first_valid_cyc", first_cyc, n0 + 3);
        check("f4_done_cyc", done_cyc, n0 + 16387);
        check("f4_done_count", done_cnt - dbase, 1);
        check("f4_all_pixels", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
